// File: rtl/decim_fir_mac_pkg.sv
// decim_fir_mac shared types and constants.
// Holds the FSM encoding and the output round/saturate helper.
package decim_fir_mac_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_COEF_W = 17;
  localparam int DEF_ACC_W  = 40;
  localparam int DEF_OUT_W  = 16;
  localparam int DEF_SHIFT  = 16;
  localparam int PROD_W     = DEF_DATA_W + DEF_COEF_W;

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    DRAIN,
    OUT
  } state_t;

  // round half up, arithmetic shift, clamp to ow-bit signed range
  function automatic logic signed [63:0] rnd_sat(
    input logic signed [63:0] a,
    input int                 sh,
    input int                 ow
  );
    logic signed [63:0] r;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    r  = (a + (64'sd1 <<< (sh - 1))) >>> sh;
    hi = (64'sd1 <<< (ow - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (ow - 1));
    if (r > hi) r = hi;
    else if (r < lo) r = lo;
    return r;
  endfunction

endpackage

// File: rtl/decim_fir_mult_reg.sv
// Registered signed x unsigned multiplier, full-width product.
// One pipeline stage; ov tracks iv so the MAC knows when p is live.
module decim_fir_mult_reg #(
  parameter int DW = 16,
  parameter int CW = 17
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     iv,
  input  logic signed [DW-1:0]     a,
  input  logic        [CW-1:0]     b,
  output logic                     ov,
  output logic signed [DW+CW-1:0]  p
);

  localparam int PW = DW + CW;

  logic signed [PW-1:0] ax;
  logic signed [PW-1:0] bx;

  assign ax = PW'(a);
  assign bx = PW'($signed({1'b0, b}));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ov <= 1'b0;
      p  <= '0;
    end else begin
      ov <= iv;
      p  <= ax * bx;
    end
  end

endmodule

// File: rtl/decim_fir_mac.sv
// Time-multiplexed polyphase decimating FIR stage.
// One tap per cycle through a registered multiplier, then round/saturate.
module decim_fir_mac
  import decim_fir_mac_pkg::*;
#(
  parameter int NTAPS  = 32,
  parameter int DECIM  = 4,
  parameter int DATA_W = DEF_DATA_W,
  parameter int COEF_W = DEF_COEF_W,
  parameter int ACC_W  = DEF_ACC_W,
  parameter int OUT_W  = DEF_OUT_W,
  parameter int SHIFT  = DEF_SHIFT
) (
  input  logic                      ap_clk,
  input  logic                      ap_rst,
  input  logic signed [DATA_W-1:0]  in_data,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic signed [OUT_W-1:0]   out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  input  logic                      coef_we,
  input  logic [$clog2(NTAPS)-1:0]  coef_addr,
  input  logic [COEF_W-1:0]         coef_data
);

  localparam int AW  = $clog2(NTAPS);
  localparam int PHW = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int PW  = DATA_W + COEF_W;

  logic signed [DATA_W-1:0] dl [NTAPS];
  logic        [COEF_W-1:0] coef [NTAPS];

  state_t                   state;
  logic        [AW-1:0]     wp;
  logic        [AW-1:0]     k;
  logic        [PHW-1:0]    phase;
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  sum;
  logic signed [PW-1:0]     prod;
  logic                     pv;
  logic signed [63:0]       rs;
  logic signed [DATA_W-1:0] xs;
  logic        [COEF_W-1:0] cs;

  // newest sample sits just behind the write pointer
  assign xs = dl[wp - AW'(1) - k];
  assign cs = coef[k];

  assign sum = pv ? acc + ACC_W'(prod) : acc;
  assign rs  = rnd_sat(64'(sum), SHIFT, OUT_W);

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == OUT);

  decim_fir_mult_reg #(
    .DW (DATA_W),
    .CW (COEF_W)
  ) u_mult (
    .clk (ap_clk),
    .rst (ap_rst),
    .iv  (state == MAC),
    .a   (xs),
    .b   (cs),
    .ov  (pv),
    .p   (prod)
  );

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state    <= IDLE;
      wp       <= '0;
      k        <= '0;
      phase    <= '0;
      acc      <= '0;
      out_data <= '0;
      for (int i = 0; i < NTAPS; i++) begin
        dl[i]   <= '0;
        coef[i] <= '0;
      end
    end else begin
      if (coef_we) coef[coef_addr] <= coef_data;
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            dl[wp] <= in_data;
            wp     <= wp + AW'(1);
            if (phase == PHW'(DECIM - 1)) begin
              phase <= '0;
              acc   <= '0;
              k     <= '0;
              state <= MAC;
            end else begin
              phase <= phase + PHW'(1);
            end
          end
        end
        MAC: begin
          acc <= sum;
          k   <= k + AW'(1);
          if (k == AW'(NTAPS - 1)) state <= DRAIN;
        end
        DRAIN: begin
          acc      <= sum;
          out_data <= OUT_W'(rs);
          state    <= OUT;
        end
        OUT: begin
          if (out_ready) state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_decim_fir_mac.sv
// Bench for decim_fir_mac: table vectors, corner sequences, random run.
// Expected outputs come from a direct convolution over the sample history.
module tb_decim_fir_mac;

  localparam int NT = 32;
  localparam int DC = 4;

  logic               ap_clk = 1'b0;
  logic               ap_rst;
  logic signed [15:0] in_data;
  logic               in_valid;
  logic               in_ready;
  logic signed [15:0] out_data;
  logic               out_valid;
  logic               out_ready;
  logic               coef_we;
  logic [4:0]         coef_addr;
  logic [16:0]        coef_data;

  decim_fir_mac dut (
    .ap_clk    (ap_clk),
    .ap_rst    (ap_rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .coef_we   (coef_we),
    .coef_addr (coef_addr),
    .coef_data (coef_data)
  );

  always #5 ap_clk = ~ap_clk;

  int checks   = 0;
  int failures = 0;

  longint cf [NT];
  longint hist [$];
  int     ph;
  longint last_out;

  typedef struct {
    string name;
    int    cval;
    bit    only0;
    int    samp;
    int    nsamp;
    int    exp;
  } vec_t;

  vec_t vt [6];

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic longint ref_out();
    longint acc;
    longint r;
    int     idx;
    acc = 0;
    for (int t = 0; t < NT; t++) begin
      idx = hist.size() - 1 - t;
      if (idx >= 0) acc += hist[idx] * cf[t];
    end
    r = (acc + 32768) >>> 16;
    if (r > 32767) r = 32767;
    if (r < -32768) r = -32768;
    return r;
  endfunction

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic model_clear();
    hist.delete();
    for (int i = 0; i < NT; i++) cf[i] = 0;
    ph = 0;
  endtask

  task automatic do_reset();
    ap_rst    = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    coef_we   = 1'b0;
    coef_addr = '0;
    coef_data = '0;
    tick();
    tick();
    ap_rst = 1'b0;
    model_clear();
  endtask

  task automatic wcoef(input int a, input longint v);
    coef_we   = 1'b1;
    coef_addr = 5'(a);
    coef_data = 17'(v);
    tick();
    coef_we = 1'b0;
    cf[a]   = v;
  endtask

  task automatic collect(input int stall, input string nm);
    int     n;
    longint d;
    n = 0;
    out_ready = 1'b0;
    while (!out_valid && n < 200) begin
      tick();
      n++;
    end
    if (!out_valid) begin
      chk({nm, "_timeout"}, 0, 1);
      return;
    end
    repeat (stall) tick();
    d = longint'(out_data);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk(nm, d, ref_out());
    last_out = d;
  endtask

  task automatic push(input longint s, input int stall, input string nm);
    int n;
    n = 0;
    while (!in_ready && n < 200) begin
      tick();
      n++;
    end
    if (!in_ready) begin
      chk({nm, "_in_ready_timeout"}, 0, 1);
      return;
    end
    in_valid = 1'b1;
    in_data  = 16'(s);
    tick();
    in_valid = 1'b0;
    hist.push_back(s);
    ph++;
    if (ph == DC) begin
      ph = 0;
      collect(stall, nm);
    end
  endtask

  initial begin
    longint           d;
    longint           ex;
    int               cnt;
    logic signed [15:0] rv;

    vt[0] = '{"rnd_pos",  98304, 1'b1,      1,  4,      2};
    vt[1] = '{"rnd_neg",  98304, 1'b1,     -1,  4,     -1};
    vt[2] = '{"tie_pos",  32768, 1'b1,      1,  4,      1};
    vt[3] = '{"tie_neg",  32768, 1'b1,     -1,  4,      0};
    vt[4] = '{"sat_pos", 131071, 1'b0,  32767, 32,  32767};
    vt[5] = '{"sat_neg", 131071, 1'b0, -32768, 32, -32768};

    // reset state
    ap_rst    = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    coef_we   = 1'b0;
    coef_addr = '0;
    coef_data = '0;
    #3;
    chk("rst_in_ready", longint'(in_ready), 1);
    chk("rst_out_valid", longint'(out_valid), 0);
    chk("rst_out_data", longint'(out_data), 0);
    do_reset();

    // table vectors: rounding ties and saturation
    for (int v = 0; v < 6; v++) begin
      do_reset();
      if (vt[v].only0) wcoef(0, vt[v].cval);
      else for (int t = 0; t < NT; t++) wcoef(t, vt[v].cval);
      for (int i = 0; i < vt[v].nsamp; i++) push(vt[v].samp, 0, vt[v].name);
      chk({vt[v].name, "_tbl"}, last_out, vt[v].exp);
    end

    // impulse through the whole delay line and past the pointer wrap
    do_reset();
    for (int t = 0; t < NT; t++) wcoef(t, 1024 * (t + 1));
    for (int i = 0; i < 64; i++) begin
      push((i == 0) ? 16384 : 0, 0, "imp_model");
      if (i % DC == DC - 1)
        chk($sformatf("imp_m%0d", i / DC), last_out,
            (i / DC < 8) ? 1024 * (i / DC + 1) : 0);
    end

    // latency, ignored input during MAC, backpressure, coef write in OUT
    do_reset();
    for (int t = 0; t < NT; t++) wcoef(t, $urandom_range(0, 131071));
    for (int i = 0; i < DC - 1; i++) push(100 * (i + 1), 0, "lat_pre");
    in_valid = 1'b1;
    in_data  = 16'sd1234;
    tick();
    hist.push_back(1234);
    ph = 0;
    ex = ref_out();
    chk("lat_in_ready_c1", longint'(in_ready), 0);
    in_data = 16'sh7abc;
    cnt = 1;
    while (!out_valid && cnt < 100) begin
      tick();
      cnt++;
    end
    in_valid = 1'b0;
    chk("lat_cycles", cnt, 34);
    d = longint'(out_data);
    chk("bp_data", d, ex);
    wcoef(5, 77777);
    for (int i = 0; i < 10; i++) begin
      chk("bp_valid_hold", longint'(out_valid), 1);
      chk("bp_data_hold", longint'(out_data), d);
      chk("bp_in_ready_low", longint'(in_ready), 0);
      tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp_valid_drop", longint'(out_valid), 0);
    chk("bp_in_ready_up", longint'(in_ready), 1);
    chk("bp_data_kept", longint'(out_data), d);
    for (int i = 0; i < DC; i++) push(-(300 * i) + 55, 1, "post_bp");

    // reset mid-MAC, then coefficients must read back as zero
    do_reset();
    for (int t = 0; t < NT; t++) wcoef(t, 1000 + t);
    for (int i = 0; i < DC - 1; i++) push(20000, 0, "mid_pre");
    in_valid = 1'b1;
    in_data  = 16'sd20000;
    tick();
    in_valid = 1'b0;
    repeat (10) tick();
    ap_rst = 1'b1;
    #1;
    chk("midrst_out_valid", longint'(out_valid), 0);
    chk("midrst_in_ready", longint'(in_ready), 1);
    tick();
    ap_rst = 1'b0;
    model_clear();
    for (int i = 0; i < DC; i++) push(12345 - i, 0, "midrst_run");
    chk("midrst_zero", last_out, 0);

    // randomized run against the convolution model
    do_reset();
    for (int t = 0; t < NT; t++) wcoef(t, $urandom_range(0, 131071));
    for (int i = 0; i < 96; i++) begin
      rv = 16'($urandom());
      push(longint'(rv), $urandom_range(0, 3), "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/decim_fir_mac.md
Name: decim_fir_mac

Overview:
- Time-multiplexed polyphase decimating FIR stage for the multirate filterbank.
- Buffers incoming 16-bit signed samples and drives the 16s x 17ns multiplier path once per tap.
- Accumulates the products, then emits one rounded, saturated output per DECIM accepted inputs.
- Sits directly upstream of the product path (it feeds the multiplier operands) and also consumes its result, closing the MAC loop.

Parameters:
NTAPS, 32, filter length; coefficient and delay-line depth (power of 2, >= 4)
DECIM, 4, decimation factor; inputs per output (>= 1)
DATA_W, 16, signed sample width
COEF_W, 17, unsigned coefficient width
ACC_W, 40, signed accumulator width
OUT_W, 16, signed output width
SHIFT, 16, right shift applied to the accumulator before output

Ports:
ap_clk  in  1  clock, all state on rising edge
ap_rst  in  1  asynchronous, active-high reset
in_data  in  DATA_W  signed input sample
in_valid  in  1  input sample valid
in_ready  out  1  stage can accept a sample
out_data  out  OUT_W  signed decimated output
out_valid  out  1  output valid
out_ready  in  1  downstream accepts output
coef_we  in  1  coefficient write strobe
coef_addr  in  log2(NTAPS)  coefficient index k
coef_data  in  COEF_W  unsigned coefficient value

Behaviour:
- Reset (async, ap_rst=1):
  - delay line and all coefficients = 0; phase counter = 0; accumulator = 0
  - state = IDLE; in_ready = 1; out_valid = 0; out_data = 0
  - Reset asserted mid-MAC or mid-OUT aborts immediately, with no output. Coefficients must be reloaded after reset.
- States: IDLE, MAC, DRAIN, OUT.
- IDLE:
  - in_ready = 1.
  - On in_valid&in_ready: sample written to circular delay line (write pointer increments mod NTAPS); phase increments.
  - When phase reaches DECIM-1 on an accept: phase <- 0, acc <- 0, tap index k <- 0, go to MAC.
- MAC (NTAPS cycles, k = 0..NTAPS-1):
  - in_ready = 0.
  - Issue operands x[n-k] (k=0 is newest sample) and coef[k].
  - Product = signed(sample) * signed({1'b0, coef}), kept at full DATA_W+COEF_W = 33 bits (no truncation), registered for 1 stage.
  - The registered product is sign-extended to ACC_W and added to acc in the following cycle.
  - After k = NTAPS-1, go to DRAIN.
- DRAIN (1 cycle):
  - Last product is added.
  - Round: r = (acc + 2^(SHIFT-1)) >>> SHIFT (round-half-up, arithmetic shift).
  - Saturate r to [-2^(OUT_W-1), 2^(OUT_W-1)-1] and register it into out_data.
  - Go to OUT.
- OUT:
  - out_valid = 1; out_data is held stable while out_valid & !out_ready.
  - On out_ready: out_valid <- 0, go to IDLE.
- Latency: DECIM-th sample accepted in cycle 0 -> out_valid first high in cycle NTAPS+2. in_ready is low from cycle 1 until the cycle after the output handshake.
- out_data keeps its last value after the handshake; it is only updated in DRAIN.
- Throughput: at most one accept per cycle in IDLE. Upstream sees backpressure through MAC/DRAIN/OUT.
- Coefficient writes:
  - Honoured in every state.
  - A read in the same cycle as a write to the same address returns the old value; the new value is visible from the next cycle.
- Boundary conditions:
  - Delay-line pointer wraps NTAPS-1 -> 0.
  - DECIM=1 enters MAC on every accept.
  - Overflow of ACC_W is impossible for default parameters (33 + log2(32) = 38 bits).

Decomposition:
- Shared package: DATA_W, COEF_W, ACC_W, OUT_W, SHIFT defaults; product width constant (DATA_W+COEF_W); state enum (IDLE, MAC, DRAIN, OUT); round/saturate function.
- One sub-module: decim_fir_mult_reg (1-stage registered 16s x 17ns -> 33-bit multiplier). The FSM, delay line and coefficient bank stay in the top module.

Test Plan:
- Impulse: coef[k] = 1024*(k+1); feed 16384 followed by 63 zeros -> outputs 1024, 2048, ..., 8192 (m = 0..7), then 0, 0, ...
- Saturation: all coef = 131071; 32 samples of 32767 -> final output 32767; repeat with -32768 -> -32768.
- Rounding: coef[0] = 98304, others 0; DECIM-th sample = 1 -> 2; DECIM-th sample = -1 -> -1.
- Backpressure: out_ready held 0 for 10 cycles -> out_valid and out_data stable, in_ready = 0 throughout; output accepted on the cycle out_ready rises; in_ready = 1 on the next cycle.
- Latency/handshake: NTAPS=32, DECIM=4, out_ready = 1 -> out_valid rises exactly 34 cycles after the 4th accept; in_valid asserted during MAC is not accepted.
- Reset mid-MAC: ap_rst pulsed at k = 10 -> out_valid = 0, in_ready = 1 immediately; a subsequent all-zero-coef run outputs 0.
